spi_word_slave: RTL and testbench

Generic SPI slave endpoint for the SPI mode-0 link driven by the team's master device. It oversamples sclk/cs_n/mosi in the system clock domain, assembles one DATA_W-bit word per cs_n frame, and shifts out a response word on miso in the same frame (full duplex, MSB first). The response word comes from a one-deep tx holding register, or from a default word when none is pending.

---
 rtl/spi_word_slave.sv | 151 +++++++++++++++
 tb/tb_spi_word_slave.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_slave.sv
// SPI mode-0 word slave: oversampled sclk/cs_n/mosi, one DATA_W-bit full-duplex word per cs_n frame.
// Optional SPI_SLV_AUTO_INC_EN: default response becomes last rx word + 1 instead of IDLE_WORD.
module spi_word_slave #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_sync_q, sclk_sync_d;
  logic [2:0]        cs_sync_q, cs_sync_d;
  logic [2:0]        mosi_sync_q, mosi_sync_d;
  logic [1:0]        prime_q, prime_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              sclk_rise, sclk_fall, cs_s, cs_fall, mosi_s;
  logic              frame_start, frame_done, frame_abort, accept;
  logic [DATA_W-1:0] default_word;
  logic [1:0]        unused_bits;

  // Index 1 is the synchronized level, index 2 the history used for edge detection.
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_s        = cs_sync_q[1];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s      = mosi_sync_q[1];
  assign unused_bits = {mosi_sync_q[2], rx_shift_q[DATA_W-1]};

  assign frame_start = (state_q == IDLE) && cs_fall;
  assign frame_done  = (state_q == SHIFT) && sclk_rise && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign frame_abort = (state_q == SHIFT) && !frame_done && cs_s;
  assign accept      = tx_valid && !pending_q;

`ifdef SPI_SLV_AUTO_INC_EN
  assign default_word = rx_data_q + DATA_W'(1);
`else
  assign default_word = IDLE_WORD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_CS_HIGH;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      prime_q     <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      prime_q     <= prime_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Leaving WAIT_CS_HIGH needs a genuine post-reset cs_n sample, not the reset value of the chain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_CS_HIGH: if (prime_q[1] && cs_s) state_d = IDLE;
      IDLE:         if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (frame_done)       state_d = WAIT_CS_HIGH;
        else if (frame_abort) state_d = IDLE;
      end
      default:      state_d = WAIT_CS_HIGH;
    endcase
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[1:0], cs_n};
    mosi_sync_d = {mosi_sync_q[1:0], mosi};
    prime_d     = {prime_q[0], 1'b1};
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = accept ? tx_data : hold_q;
    pending_d   = accept || (pending_q && !frame_start);
    rx_data_d   = rx_data_q;
    done_d      = frame_done;
    rx_valid_d  = done_q;
    frame_err_d = frame_abort;
    // A word accepted in the frame-start cycle sees pending_q low, so it waits for the next frame.
    if (frame_start) begin
      tx_shift_d = pending_q ? hold_q : default_word;
      bit_cnt_d  = '0;
    end
    if (state_q == SHIFT) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      end
      if (sclk_fall && (bit_cnt_q != '0)) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
    end
    if (frame_done) rx_data_d = {rx_shift_q[DATA_W-2:0], mosi_s};
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    miso      = (state_q == SHIFT) && tx_shift_q[DATA_W-1];
    tx_ready  = !pending_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_spi_word_slave.sv
// Self-checking bench for spi_word_slave: a mode-0 master task plus a word-level reference model.
module tb_spi_word_slave;
  localparam int          DATA_W    = 32;
  localparam logic [31:0] IDLE_WORD = 32'hDEADBEEF;
  localparam int          HALF      = 5;

  logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic        miso, tx_ready, rx_valid, busy, frame_err;
  logic [31:0] rx_data;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, rv_cnt = 0, fe_cnt = 0, rv_cyc = 0, rise_cyc = 0;

  logic [31:0] m_rx = '0, m_hold = '0;
  bit          m_pend = 1'b0;

  spi_word_slave #(.DATA_W(DATA_W), .IDLE_WORD(IDLE_WORD)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid) begin rv_cnt++; rv_cyc = cyc; end
    if (frame_err) fe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_default();
`ifdef SPI_SLV_AUTO_INC_EN
    return m_rx + 32'd1;
`else
    return IDLE_WORD;
`endif
  endfunction

  // Response for a frame starting now; a coincident push becomes the next pending word.
  task automatic model_start(input bit coinc, input logic [31:0] cw, output logic [31:0] exp);
    exp    = m_pend ? m_hold : model_default();
    m_pend = 1'b0;
    if (coinc) begin m_pend = 1'b1; m_hold = cw; end
  endtask

  task automatic cs_low(input bit coinc, input logic [31:0] cw);
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk); @(negedge clk);
    if (coinc) begin tx_data = cw; tx_valid = 1'b1; end
    @(negedge clk);
    if (coinc) tx_valid = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[31-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1; rise_cyc = cyc; cap = {cap[30:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic full_frame(input logic [31:0] mw, input bit coinc, input logic [31:0] cw,
                            output logic [31:0] cap);
    cs_low(coinc, cw);
    send_bits(mw, 32, cap);
    cs_high();
  endtask

  task automatic push(input logic [31:0] w);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_wait: tx_ready=%b required 1", tx_ready);
    end
    tx_data = w; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    m_pend = 1'b1; m_hold = w;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({miso, tx_ready, rx_valid, busy, frame_err} !== 5'b01000 || rx_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_in: miso/rdy/vld/busy/err=%b rx=%h required 01000 0",
                         {miso, tx_ready, rx_valid, busy, frame_err}, rx_data);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({miso, tx_ready, rx_valid, busy, frame_err} !== 5'b01000 || rx_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: miso/rdy/vld/busy/err=%b rx=%h required 01000 0",
                         {miso, tx_ready, rx_valid, busy, frame_err}, rx_data);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp, cap;
    int rv0;
    push(32'hA5A50F0F);
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full: tx_ready=%b required 0", tx_ready); end
    model_start(1'b0, '0, exp);
    rv0 = rv_cnt;
    cs_low(1'b0, '0);
    n_checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: tx_ready=%b busy=%b required 1 1", tx_ready, busy);
    end
    send_bits(32'h12345678, 32, cap);
    cs_high();
    m_rx = 32'h12345678;
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL basic_miso: got %h required %h", cap, exp); end
    n_checks++;
    if (rx_data !== 32'h12345678) begin n_fail++; $display("FAIL basic_rx: got %h required 12345678", rx_data); end
    n_checks++;
    if (rv_cnt !== rv0 + 1) begin n_fail++; $display("FAIL basic_pulses: got %0d required %0d", rv_cnt - rv0, 1); end
    n_checks++;
    if (rv_cyc - rise_cyc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d required 4", rv_cyc - rise_cyc); end
  endtask

  task automatic test_default();
    logic [31:0] exp, cap, mw;
    model_start(1'b0, '0, exp);
    full_frame(32'h000000FF, 1'b0, '0, cap);
    m_rx = 32'h000000FF;
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL dflt_first: got %h required %h", cap, exp); end
    mw = $urandom;
    model_start(1'b0, '0, exp);
    full_frame(mw, 1'b0, '0, cap);
    m_rx = mw;
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL dflt_second: got %h required %h", cap, exp); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp, cap;
    model_start(1'b0, '0, exp);
    full_frame(32'hFFFFFFFF, 1'b0, '0, cap);
    m_rx = 32'hFFFFFFFF;
    model_start(1'b0, '0, exp);
    full_frame(32'h0000AAAA, 1'b0, '0, cap);
    m_rx = 32'h0000AAAA;
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL wrap_resp: got %h required %h", cap, exp); end
  endtask

  task automatic test_abort();
    logic [31:0] exp, cap, mw;
    int rv0, fe0;
    push($urandom);
    rv0 = rv_cnt; fe0 = fe_cnt;
    model_start(1'b0, '0, exp);
    mw = $urandom;
    cs_low(1'b0, '0);
    send_bits(mw, 17, cap);
    cs_high();
    n_checks++;
    if (fe_cnt !== fe0 + 1) begin n_fail++; $display("FAIL abort_err: pulses %0d required 1", fe_cnt - fe0); end
    n_checks++;
    if (rv_cnt !== rv0) begin n_fail++; $display("FAIL abort_vld: pulses %0d required 0", rv_cnt - rv0); end
    n_checks++;
    if (rx_data !== m_rx) begin n_fail++; $display("FAIL abort_rx: got %h required %h", rx_data, m_rx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_rdy: tx_ready=%b required 1", tx_ready); end
    n_checks++;
    if (cap[16:0] !== exp[31:15]) begin n_fail++; $display("FAIL abort_miso: got %h required %h", cap[16:0], exp[31:15]); end
    model_start(1'b0, '0, exp);
    mw = $urandom;
    full_frame(mw, 1'b0, '0, cap);
    m_rx = mw;
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL abort_next: got %h required %h", cap, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1, exp2, cap1, cap2, w2, w3, mw;
    bit stalled = 1'b1;
    int k = 0;
    w2 = $urandom; w3 = $urandom;
    push($urandom);
    @(negedge clk); tx_data = w2; tx_valid = 1'b1;
    repeat (10) begin @(negedge clk); if (tx_ready !== 1'b0) stalled = 1'b0; end
    n_checks++;
    if (!stalled) begin n_fail++; $display("FAIL b2b_stall: tx_ready rose while pending, required 0"); end
    model_start(1'b1, w2, exp1);
    mw = $urandom;
    fork
      full_frame(mw, 1'b0, '0, cap1);
      begin
        while (!tx_ready && k < 200) begin @(negedge clk); k++; end
        @(negedge clk); tx_valid = 1'b0;
      end
    join
    m_rx = mw;
    n_checks++;
    if (cap1 !== exp1) begin n_fail++; $display("FAIL b2b_first: got %h required %h", cap1, exp1); end
    model_start(1'b0, '0, exp2);
    mw = $urandom;
    full_frame(mw, 1'b0, '0, cap2);
    m_rx = mw;
    n_checks++;
    if (cap2 !== exp2) begin n_fail++; $display("FAIL b2b_second: got %h required %h", cap2, exp2); end
    model_start(1'b1, w3, exp1);
    mw = $urandom;
    full_frame(mw, 1'b1, w3, cap1);
    m_rx = mw;
    n_checks++;
    if (cap1 !== exp1 || tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL coinc_frame: got %h rdy %b required %h rdy 0", cap1, tx_ready, exp1);
    end
    model_start(1'b0, '0, exp2);
    mw = $urandom;
    full_frame(mw, 1'b0, '0, cap2);
    m_rx = mw;
    n_checks++;
    if (cap2 !== exp2) begin n_fail++; $display("FAIL coinc_next: got %h required %h", cap2, exp2); end
  endtask

  task automatic test_random();
    logic [31:0] exp, cap, mw, cw;
    bit coinc;
    for (int n = 0; n < 6; n++) begin
      if (!m_pend && $urandom_range(1, 0) == 1) push($urandom);
      coinc = !m_pend && ($urandom_range(3, 0) == 0);
      cw = $urandom; mw = $urandom;
      model_start(coinc, cw, exp);
      full_frame(mw, coinc, cw, cap);
      m_rx = mw;
      n_checks++;
      if (cap !== exp || rx_data !== mw) begin
        n_fail++; $display("FAIL rand_frame%0d: miso %h rx %h required %h %h", n, cap, rx_data, exp, mw);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp, cap;
    int rv0, fe0;
    cs_low(1'b0, '0);
    send_bits($urandom, 10, cap);
    rv0 = rv_cnt; fe0 = fe_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_rx = '0; m_pend = 1'b0;
    send_bits($urandom, 8, cap);
    repeat (10) @(negedge clk);
    n_checks++;
    if ({miso, tx_ready, rx_valid, busy, frame_err} !== 5'b01000 || rx_data !== 32'h0 || cap[7:0] !== 8'h0) begin
      n_fail++; $display("FAIL rst_mid_state: miso/rdy/vld/busy/err=%b rx=%h miso_bits=%h required 01000 0 0",
                         {miso, tx_ready, rx_valid, busy, frame_err}, rx_data, cap[7:0]);
    end
    n_checks++;
    if (rv_cnt !== rv0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL rst_mid_pulses: vld %0d err %0d required 0 0", rv_cnt - rv0, fe_cnt - fe0);
    end
    cs_high();
    model_start(1'b0, '0, exp);
    full_frame(32'h0F0F0F0F, 1'b0, '0, cap);
    m_rx = 32'h0F0F0F0F;
    n_checks++;
    if (rx_data !== 32'h0F0F0F0F || cap !== exp) begin
      n_fail++; $display("FAIL rst_mid_frame: rx %h miso %h required 0f0f0f0f %h", rx_data, cap, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_default();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
